// File: rtl/ln_pkg.sv
// Shared definitions for the LayerNorm datapath stages: lane geometry,
// fixed-point format and the lane-slicing helper.
package ln_pkg;

    localparam int LANES  = 16;
    localparam int Q_W    = 16;
    localparam int Q_FRAC = 8;

    localparam logic [Q_W-1:0] VAR_SAT_VAL = 16'hFFFF;

    function automatic logic [Q_W-1:0] lane_slice(input logic [LANES*Q_W-1:0] flat, input int idx);
        return flat[idx*Q_W +: Q_W];
    endfunction

endpackage

// File: rtl/ln_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear, used to
// align vectors with late-arriving side data.
module ln_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= din;
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/ln_var_tree.sv
// LayerNorm variance stage: aligns each vector with its mean, then computes
// the biased variance through diff/square/adder-tree/scale pipeline stages.
module ln_var_tree
    import ln_pkg::*;
#(
    parameter int MEAN_LAT = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         x_valid,
    input  logic [255:0] x_in_flat,
    input  logic [15:0]  mean_in,
    output logic         var_valid,
    output logic [15:0]  var_out,
    output logic         var_sat,
    output logic [255:0] x_out_flat,
    output logic [15:0]  mean_out
);

    localparam int VEC_W      = LANES * Q_W;
    localparam int PASS_DEPTH = 7;

    // Align the vector and its valid bit with the mean tree output.
    logic [VEC_W:0]   align_in;
    logic [VEC_W:0]   align_out;
    logic             a_valid;
    logic [VEC_W-1:0] a_x;

    assign align_in = {x_valid, x_in_flat};

    ln_delay_line #(.WIDTH(VEC_W + 1), .DEPTH(MEAN_LAT)) u_align (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (align_in),
        .dout (align_out)
    );

    assign a_valid = align_out[VEC_W];
    assign a_x     = align_out[VEC_W-1:0];

    logic [VEC_W+Q_W-1:0] pass_in;
    logic [VEC_W+Q_W-1:0] pass_out;

    assign pass_in = {a_x, mean_in};

    ln_delay_line #(.WIDTH(VEC_W + Q_W), .DEPTH(PASS_DEPTH)) u_pass (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pass_in),
        .dout (pass_out)
    );

    assign x_out_flat = pass_out[VEC_W+Q_W-1:Q_W];
    assign mean_out   = pass_out[Q_W-1:0];

    logic [PASS_DEPTH-1:0] valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_reg <= '0;
        else        valid_reg <= {valid_reg[PASS_DEPTH-2:0], a_valid};
    end

    assign var_valid = valid_reg[PASS_DEPTH-1];

    logic signed [16:0] diff_reg [LANES];
    logic signed [33:0] prod     [LANES];
    logic [24:0]        sq_reg   [LANES];
    logic [25:0]        l3_reg   [8];
    logic [26:0]        l4_reg   [4];
    logic [27:0]        l5_reg   [2];
    logic [28:0]        sum_reg;
    logic [24:0]        scaled;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [Q_W-1:0] lane_x;
            assign lane_x   = lane_slice(a_x, gi);
            assign prod[gi] = diff_reg[gi] * diff_reg[gi];

            // An unaligned slot loads zero so a stray mean_in never toggles the datapath.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    diff_reg[gi] <= '0;
                    sq_reg[gi]   <= '0;
                end else begin
                    diff_reg[gi] <= a_valid ? ($signed({lane_x[Q_W-1], lane_x}) - $signed({mean_in[Q_W-1], mean_in}))
                                            : 17'sd0;
                    sq_reg[gi]   <= 25'(prod[gi] >> Q_FRAC);
                end
            end
        end

        for (gi = 0; gi < 8; gi++) begin : g_l3
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) l3_reg[gi] <= '0;
                else        l3_reg[gi] <= 26'(sq_reg[2*gi]) + 26'(sq_reg[2*gi+1]);
            end
        end

        for (gi = 0; gi < 4; gi++) begin : g_l4
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) l4_reg[gi] <= '0;
                else        l4_reg[gi] <= 27'(l3_reg[2*gi]) + 27'(l3_reg[2*gi+1]);
            end
        end

        for (gi = 0; gi < 2; gi++) begin : g_l5
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) l5_reg[gi] <= '0;
                else        l5_reg[gi] <= 28'(l4_reg[2*gi]) + 28'(l4_reg[2*gi+1]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_reg <= '0;
        else        sum_reg <= 29'(l5_reg[0]) + 29'(l5_reg[1]);
    end

    // Divide by the lane count, then clip to the 16-bit output range.
    assign scaled = 25'(sum_reg >> 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            var_out <= '0;
            var_sat <= 1'b0;
        end else if (scaled > 25'(VAR_SAT_VAL)) begin
            var_out <= VAR_SAT_VAL;
            var_sat <= 1'b1;
        end else begin
            var_out <= scaled[15:0];
            var_sat <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ln_var_tree.sv
// Scoreboard bench for ln_var_tree: expected results are queued when a vector
// is driven and compared when var_valid presents them.
module tb_ln_var_tree;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         x_valid = 1'b0;
    logic [255:0] x_in_flat = '0;
    logic [15:0]  mean_in = '0;
    logic         var_valid;
    logic [15:0]  var_out;
    logic         var_sat;
    logic [255:0] x_out_flat;
    logic [15:0]  mean_out;

    ln_var_tree #(.MEAN_LAT(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_valid   (x_valid),
        .x_in_flat (x_in_flat),
        .mean_in   (mean_in),
        .var_valid (var_valid),
        .var_out   (var_out),
        .var_sat   (var_sat),
        .x_out_flat(x_out_flat),
        .mean_out  (mean_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] x;
        logic [15:0]  m;
        logic [15:0]  v;
        logic         s;
        int           c;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mean_hist[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: floor((sum floor((x_i-m)^2 / 256)) / 16), saturated to 16 bits.
    function automatic logic [16:0] model(input logic [255:0] x, input logic [15:0] m);
        longint sum = 0;
        longint v;
        for (int i = 0; i < 16; i++) begin
            logic signed [15:0] a;
            longint d;
            a = x[i*16 +: 16];
            d = longint'(a) - longint'($signed(m));
            sum += (d * d) / 256;
        end
        v = sum / 16;
        if (v > 65535) return {1'b1, 16'hFFFF};
        return {1'b0, 16'(v)};
    endfunction

    function automatic logic [255:0] alt_vec(input logic [15:0] a, input logic [15:0] b);
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = (i % 2 == 0) ? a : b;
        return r;
    endfunction

    function automatic logic [255:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle of stimulus; the mean for a vector is presented 5 cycles later.
    task automatic drive(input logic v, input logic [255:0] x, input logic [15:0] m);
        logic [16:0] r;
        x_valid   = v;
        x_in_flat = v ? x : rand_vec();
        mean_hist.push_back(v ? m : 16'($urandom));
        if (mean_hist.size() > 5) mean_in = mean_hist.pop_front();
        else                      mean_in = 16'($urandom);
        if (v) begin
            r = model(x, m);
            sb.push_back('{x: x, m: m, v: r[15:0], s: r[16], c: cyc + 12});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic one_vec(input logic [255:0] x, input logic [15:0] m);
        drive(1'b1, x, m);
        repeat (14) drive(1'b0, '0, '0);
        check_val("drain_single", 256'(sb.size()), 256'(0));
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_valid"}, 256'(var_valid), 256'(0));
        check_val({tag, "_var"},   256'(var_out),   256'(0));
        check_val({tag, "_sat"},   256'(var_sat),   256'(0));
        check_val({tag, "_x"},     x_out_flat,      256'(0));
        check_val({tag, "_mean"},  256'(mean_out),  256'(0));
    endtask

    task automatic stream(input logic do_reset);
        for (int r = 0; r <= 20; r++) begin
            if (do_reset && r == 8) begin
                rst_n = 1'b0;
                #1;
                check_zero_outputs("mid_reset");
                sb.delete();
                #2;
                rst_n = 1'b1;
            end
            if (do_reset && r > 8) check_val("rst_quiet", 256'(var_valid), 256'(0));
            drive((r <= 2) || (r == 4), rand_vec(), 16'($urandom));
        end
        check_val("drain_stream", 256'(sb.size()), 256'(0));
    endtask

    always @(negedge clk) begin
        if (var_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", 256'(1), 256'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn cyc=%0d var=%h sat=%b mean=%h", cyc, var_out, var_sat, mean_out);
                check_val("latency", 256'(cyc),     256'(e.c));
                check_val("var",     256'(var_out), 256'(e.v));
                check_val("sat",     256'(var_sat), 256'(e.s));
                check_val("mean",    256'(mean_out), 256'(e.m));
                check_val("x_out",   x_out_flat,    e.x);
            end
        end
    end

    initial begin
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;

        one_vec(alt_vec(16'h0100, 16'h0100), 16'h0100);
        one_vec(alt_vec(16'h0200, 16'h0000), 16'h0100);
        one_vec(alt_vec(16'hFE00, 16'h0200), 16'h0000);
        one_vec(alt_vec(16'h0101, 16'h0100), 16'h0100);
        one_vec(alt_vec(16'h7FFF, 16'h7FFF), 16'h8000);

        stream(1'b0);
        stream(1'b1);

        for (int i = 0; i < 30; i++) drive(($urandom_range(9, 0) < 7), rand_vec(), 16'($urandom));
        repeat (16) drive(1'b0, '0, '0);
        check_val("drain_burst", 256'(sb.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
